// File: rtl/vdc_vram_arbiter_pkg.sv
// Shared types and constants for the VDC VRAM port arbiter.
package vdc_vram_arbiter_pkg;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } vram_req_t;

    typedef enum logic [1:0] {GNT_IDLE, GNT_BG, GNT_CPU, GNT_DMA} grant_t;

    localparam logic [7:0] BG_SLOT_MASK_DEFAULT = 8'b1010_0010;

endpackage

// File: rtl/vram_req_slot.sv
// Single-entry pending buffer: accepts a request when empty, drops it when issued.
module vram_req_slot
    import vdc_vram_arbiter_pkg::*;
(
    input  logic        clock,
    input  logic        reset_N,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        clear,
    output logic        ack,
    output vram_req_t   entry,
    output logic        valid
);

    assign ack = req && !valid;

    // ack needs !valid and clear needs valid, so the two never coincide.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            valid <= 1'b0;
            entry <= '0;
        end else if (ack) begin
            valid <= 1'b1;
            entry <= '{we: we, addr: addr, wdata: wdata};
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/vdc_vram_arbiter.sv
// Time-slot arbiter for the VDC VRAM port: BG fetch slots, then CPU/DMA with DMA anti-starvation.
// Optional DMA port is built only when VDC_VRAM_DMA_EN is defined.
module vdc_vram_arbiter
    import vdc_vram_arbiter_pkg::*;
#(
    parameter logic [7:0]  BG_SLOT_MASK = BG_SLOT_MASK_DEFAULT,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_N,
    input  logic [2:0]  char_cycle,
    input  logic        bg_active,
    input  logic [15:0] bg_addr,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_rvalid,
    output logic [15:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_ack,
    output logic        dma_rvalid,
    output logic [15:0] dma_rdata,
    output logic [15:0] MA,
    output logic [15:0] MD_out,
    input  logic [15:0] MD_in,
    output logic        vram_re,
    output logic        vram_we
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic      bg_slot;
    logic      starved;
    logic      cpu_valid, dma_valid;
    logic      cpu_clear, dma_clear;
    vram_req_t cpu_entry, dma_entry, issue_req;
    grant_t    grant, tag_q;

    assign bg_slot   = bg_active && BG_SLOT_MASK[char_cycle];
    assign cpu_clear = (grant == GNT_CPU);
    assign dma_clear = (grant == GNT_DMA);

    vram_req_slot u_cpu_slot (
        .clock   (clock),
        .reset_N (reset_N),
        .req     (cpu_req),
        .we      (cpu_we),
        .addr    (cpu_addr),
        .wdata   (cpu_wdata),
        .clear   (cpu_clear),
        .ack     (cpu_ack),
        .entry   (cpu_entry),
        .valid   (cpu_valid)
    );

`ifdef VDC_VRAM_DMA_EN
    logic [3:0] starve_cnt;

    vram_req_slot u_dma_slot (
        .clock   (clock),
        .reset_N (reset_N),
        .req     (dma_req),
        .we      (dma_we),
        .addr    (dma_addr),
        .wdata   (dma_wdata),
        .clear   (dma_clear),
        .ack     (dma_ack),
        .entry   (dma_entry),
        .valid   (dma_valid)
    );

    assign starved = (starve_cnt == STARVE_MAX);

    // Counts CPU wins while DMA waits; any DMA issue or empty DMA buffer restarts it.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            starve_cnt <= 4'd0;
        end else if (grant == GNT_DMA || !dma_valid) begin
            starve_cnt <= 4'd0;
        end else if (grant == GNT_CPU && !starved) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    logic unused_dma;

    assign dma_ack    = 1'b0;
    assign dma_valid  = 1'b0;
    assign dma_entry  = '0;
    assign starved    = 1'b0;
    assign unused_dma = ^{dma_req, dma_we, dma_addr, dma_wdata, STARVE_MAX};
`endif

    always_comb begin
        grant = GNT_IDLE;
        if (bg_slot)                    grant = GNT_BG;
        else if (dma_valid && starved)  grant = GNT_DMA;
        else if (cpu_valid)             grant = GNT_CPU;
        else if (dma_valid)             grant = GNT_DMA;
    end

    assign issue_req = (grant == GNT_DMA) ? dma_entry : cpu_entry;

    always_comb begin
        MA      = '0;
        MD_out  = '0;
        vram_re = 1'b0;
        vram_we = 1'b0;
        unique case (grant)
            GNT_BG: begin
                MA      = bg_addr;
                vram_re = 1'b1;
            end
            GNT_CPU, GNT_DMA: begin
                MA      = issue_req.addr;
                vram_we = issue_req.we;
                vram_re = !issue_req.we;
                MD_out  = issue_req.we ? issue_req.wdata : 16'h0000;
            end
            default: ;
        endcase
    end

    // tag_q marks who owns the read whose data is on MD_in this cycle.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            tag_q      <= GNT_IDLE;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            tag_q      <= ((cpu_clear || dma_clear) && !issue_req.we) ? grant : GNT_IDLE;
            cpu_rvalid <= (tag_q == GNT_CPU);
            dma_rvalid <= (tag_q == GNT_DMA);
            if (tag_q == GNT_CPU) cpu_rdata <= MD_in;
            if (tag_q == GNT_DMA) dma_rdata <= MD_in;
        end
    end

endmodule

// File: tb/tb_vdc_vram_arbiter.sv
// Self-checking bench for vdc_vram_arbiter: directed scenarios plus randomized traffic vs a cycle model.
module tb_vdc_vram_arbiter;

`ifdef VDC_VRAM_DMA_EN
    localparam bit DMA_EN = 1'b1;
`else
    localparam bit DMA_EN = 1'b0;
`endif
    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset_N;
    logic [2:0]  char_cycle;
    logic        bg_active;
    logic [15:0] bg_addr;
    logic        cpu_req, cpu_we, cpu_ack, cpu_rvalid;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_ack, dma_rvalid;
    logic [15:0] dma_addr, dma_wdata, dma_rdata;
    logic [15:0] MA, MD_out, MD_in;
    logic        vram_re, vram_we;

    vdc_vram_arbiter dut (
        .clock      (clock),
        .reset_N    (reset_N),
        .char_cycle (char_cycle),
        .bg_active  (bg_active),
        .bg_addr    (bg_addr),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_ack    (dma_ack),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .MA         (MA),
        .MD_out     (MD_out),
        .MD_in      (MD_in),
        .vram_re    (vram_re),
        .vram_we    (vram_we)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] mask_v = 8'b1010_0010;

    // Reference model: pending requests, starvation count, queue of outstanding reads.
    typedef struct { int due; bit dma; } ret_t;
    ret_t        rq[$];
    bit          m_cpu_v, m_cpu_we, m_dma_v, m_dma_we;
    logic [15:0] m_cpu_addr, m_cpu_wd, m_dma_addr, m_dma_wd;
    int          m_starve;
    bit          m_cpu_rv, m_dma_rv, m_last_ack_c, m_last_ack_d;
    logic [15:0] m_cpu_rdata, m_dma_rdata;

    task automatic model_reset();
        rq.delete();
        m_cpu_v = 0; m_dma_v = 0; m_starve = 0;
        m_cpu_rv = 0; m_dma_rv = 0; m_cpu_rdata = 0; m_dma_rdata = 0;
        m_last_ack_c = 0; m_last_ack_d = 0;
    endtask

    // 0 idle, 1 background, 2 cpu, 3 dma
    function automatic int m_who();
        if (bg_active && mask_v[char_cycle]) return 1;
        if (m_dma_v && m_starve == LIMIT) return 3;
        if (m_cpu_v) return 2;
        if (m_dma_v) return 3;
        return 0;
    endfunction

    task automatic m_outputs(output logic [15:0] ma, output logic [15:0] md,
                             output logic re, output logic we);
        int w;
        w = m_who();
        ma = 0; md = 0; re = 0; we = 0;
        if (w == 1) begin ma = bg_addr; re = 1; end
        if (w == 2) begin
            ma = m_cpu_addr; we = m_cpu_we; re = !m_cpu_we; md = m_cpu_we ? m_cpu_wd : 16'h0;
        end
        if (w == 3) begin
            ma = m_dma_addr; we = m_dma_we; re = !m_dma_we; md = m_dma_we ? m_dma_wd : 16'h0;
        end
    endtask

    task automatic advance();
        int w;
        bit ac, ad;
        @(posedge clock);
        if (!reset_N) begin
            model_reset();
        end else begin
            w  = m_who();
            ac = cpu_req && !m_cpu_v;
            ad = DMA_EN && dma_req && !m_dma_v;
            m_cpu_rv = 0; m_dma_rv = 0;
            if (rq.size() > 0 && rq[0].due == cyc + 1) begin
                if (rq[0].dma) begin m_dma_rv = 1; m_dma_rdata = MD_in; end
                else begin m_cpu_rv = 1; m_cpu_rdata = MD_in; end
                void'(rq.pop_front());
            end
            if (w == 2 && !m_cpu_we) rq.push_back('{cyc + 2, 1'b0});
            if (w == 3 && !m_dma_we) rq.push_back('{cyc + 2, 1'b1});
            if (w == 3 || !m_dma_v) m_starve = 0;
            else if (w == 2 && m_starve < LIMIT) m_starve++;
            if (w == 2) m_cpu_v = 0;
            if (w == 3) m_dma_v = 0;
            if (ac) begin m_cpu_v = 1; m_cpu_we = cpu_we; m_cpu_addr = cpu_addr; m_cpu_wd = cpu_wdata; end
            if (ad) begin m_dma_v = 1; m_dma_we = dma_we; m_dma_addr = dma_addr; m_dma_wd = dma_wdata; end
            m_last_ack_c = ac; m_last_ack_d = ad;
        end
        cyc++;
        #1;
    endtask

    task automatic drive_random(input bit fix_dma);
        if (!(cpu_req && !m_last_ack_c)) begin
            cpu_req   = ($urandom_range(0, 2) != 0);
            cpu_we    = 1'($urandom);
            cpu_addr  = fix_dma ? 16'($urandom_range(0, 16'h0FFF)) : 16'($urandom);
            cpu_wdata = 16'($urandom);
        end
        if (fix_dma) begin
            dma_req = 1; dma_we = 0; dma_addr = 16'hDDDD; dma_wdata = 16'hDDDD;
        end else if (!(dma_req && !m_last_ack_d)) begin
            dma_req   = ($urandom_range(0, 2) != 0);
            dma_we    = 1'($urandom);
            dma_addr  = 16'($urandom);
            dma_wdata = 16'($urandom);
        end
        bg_active = 1'($urandom);
        bg_addr   = fix_dma ? 16'($urandom_range(0, 16'h0FFF)) : 16'($urandom);
        MD_in     = 16'($urandom);
    endtask

    task automatic test_reset();
        reset_N = 0; model_reset();
        cpu_req = 0; dma_req = 0; bg_active = 0; char_cycle = 0; MD_in = 0;
        @(negedge clock);
        checks += 6;
        if (cpu_ack !== 0 || dma_ack !== 0) begin errors++; $display("FAIL reset_ack: got %b/%b want 0/0", cpu_ack, dma_ack); end
        if (cpu_rvalid !== 0 || dma_rvalid !== 0) begin errors++; $display("FAIL reset_rvalid: got %b/%b want 0/0", cpu_rvalid, dma_rvalid); end
        if (cpu_rdata !== 0) begin errors++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
        if (dma_rdata !== 0) begin errors++; $display("FAIL reset_dma_rdata: got %h want 0", dma_rdata); end
        if (MA !== 0 || MD_out !== 0) begin errors++; $display("FAIL reset_bus: got MA=%h MD=%h want 0", MA, MD_out); end
        if (vram_re !== 0 || vram_we !== 0) begin errors++; $display("FAIL reset_strobes: got %b%b want 00", vram_re, vram_we); end
        advance(); advance();
        reset_N = 1;
    endtask

    task automatic test_bg_slots();
        bg_active = 1; bg_addr = 16'h0040;
        for (int c = 0; c < 8; c++) begin
            char_cycle = 3'(c);
            @(negedge clock);
            checks += 2;
            if (MA !== (mask_v[c] ? 16'h0040 : 16'h0000)) begin errors++; $display("FAIL bg_ma c%0d: got %h want %h", c, MA, mask_v[c] ? 16'h0040 : 16'h0); end
            if (vram_re !== mask_v[c] || vram_we !== 0) begin errors++; $display("FAIL bg_strobe c%0d: got re=%b we=%b want re=%b we=0", c, vram_re, vram_we, mask_v[c]); end
            advance();
        end
    endtask

    task automatic test_cpu_read();
        bg_active = 1; bg_addr = 16'h0040; MD_in = 0;
        char_cycle = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234; cpu_wdata = 0;
        @(negedge clock);
        checks++; if (cpu_ack !== 1) begin errors++; $display("FAIL rd_ack: got %b want 1", cpu_ack); end
        advance(); cpu_req = 0; char_cycle = 1;
        @(negedge clock);
        checks++; if (MA !== 16'h0040) begin errors++; $display("FAIL rd_bg_cycle: got MA=%h want 0040", MA); end
        advance(); char_cycle = 2;
        @(negedge clock);
        checks++; if (MA !== 16'h1234 || vram_re !== 1 || vram_we !== 0) begin errors++; $display("FAIL rd_issue: got MA=%h re=%b we=%b want 1234/1/0", MA, vram_re, vram_we); end
        advance(); char_cycle = 3; MD_in = 16'hBEEF;
        @(negedge clock);
        checks++; if (cpu_rvalid !== 0) begin errors++; $display("FAIL rd_early: got rvalid=%b want 0", cpu_rvalid); end
        advance(); char_cycle = 4; MD_in = 16'h0000;
        @(negedge clock);
        checks++; if (cpu_rvalid !== 1 || cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_return: got %b/%h want 1/beef", cpu_rvalid, cpu_rdata); end
        advance(); char_cycle = 6;
        @(negedge clock);
        checks++; if (cpu_rvalid !== 0 || cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_hold: got %b/%h want 0/beef", cpu_rvalid, cpu_rdata); end
        advance();
    endtask

    task automatic test_cpu_write();
        bg_active = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0100; cpu_wdata = 16'hA5A5;
        @(negedge clock);
        checks++; if (cpu_ack !== 1 || vram_we !== 0) begin errors++; $display("FAIL wr_ack: got ack=%b we=%b want 1/0", cpu_ack, vram_we); end
        advance(); cpu_req = 0;
        @(negedge clock);
        checks++;
        if (vram_we !== 1 || vram_re !== 0 || MA !== 16'h0100 || MD_out !== 16'hA5A5) begin
            errors++; $display("FAIL wr_issue: got we=%b re=%b MA=%h MD=%h want 1/0/0100/a5a5", vram_we, vram_re, MA, MD_out);
        end
        for (int k = 0; k < 3; k++) begin
            advance();
            @(negedge clock);
            checks++; if (cpu_rvalid !== 0) begin errors++; $display("FAIL wr_no_rvalid: got %b want 0", cpu_rvalid); end
        end
        advance();
    endtask

    task automatic test_hold();
        bg_active = 1; bg_addr = 16'h0040; char_cycle = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h2222;
        @(negedge clock);
        checks++; if (cpu_ack !== 1) begin errors++; $display("FAIL hold_first_ack: got %b want 1", cpu_ack); end
        advance(); cpu_addr = 16'h3333;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++; if (cpu_ack !== 0 || MA !== 16'h0040) begin errors++; $display("FAIL hold_wait: got ack=%b MA=%h want 0/0040", cpu_ack, MA); end
            advance();
        end
        char_cycle = 0;
        @(negedge clock);
        checks++; if (cpu_ack !== 0 || MA !== 16'h2222) begin errors++; $display("FAIL hold_issue: got ack=%b MA=%h want 0/2222", cpu_ack, MA); end
        advance();
        @(negedge clock);
        checks++; if (cpu_ack !== 1) begin errors++; $display("FAIL hold_reack: got %b want 1", cpu_ack); end
        advance(); cpu_req = 0;
        @(negedge clock);
        checks++; if (MA !== 16'h3333) begin errors++; $display("FAIL hold_second_issue: got MA=%h want 3333", MA); end
        advance(); advance(); advance();
    endtask

    task automatic test_reset_midflight();
        bg_active = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4444; MD_in = 16'h7777;
        advance(); cpu_req = 0;
        @(negedge clock);
        checks++; if (MA !== 16'h4444) begin errors++; $display("FAIL mid_issue: got MA=%h want 4444", MA); end
        advance();
        reset_N = 0; model_reset();
        advance(); advance();
        reset_N = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks += 2;
            if (cpu_rvalid !== 0 || cpu_rdata !== 0) begin errors++; $display("FAIL mid_rvalid: got %b/%h want 0/0", cpu_rvalid, cpu_rdata); end
            if (MA !== 0 || vram_re !== 0 || vram_we !== 0 || cpu_ack !== 0) begin
                errors++; $display("FAIL mid_outputs: got MA=%h re=%b we=%b ack=%b want idle", MA, vram_re, vram_we, cpu_ack);
            end
            advance();
        end
    endtask

    task automatic test_starvation();
        int cpu_n, dma_n;
        bit sc, sd, issued;
        logic [15:0] ca;
        bg_active = 1; bg_addr = 16'h0040; cpu_we = 0; dma_we = 0;
        ca = 16'hC000; cpu_req = 1; cpu_addr = ca; dma_req = 1; dma_addr = 16'hD000;
        cpu_n = 0; dma_n = 0;
        for (int k = 0; k < 60 && dma_n < 2; k++) begin
            char_cycle = (k % 2 == 1) ? 3'd0 : 3'd1;
            MD_in = 16'($urandom);
            @(negedge clock);
            sc = cpu_ack; sd = dma_ack; issued = 0;
            if (vram_re && MA[15:12] == 4'hD) begin
                checks++;
                if (cpu_n != LIMIT) begin errors++; $display("FAIL starve_count: got %0d cpu issues want %0d", cpu_n, LIMIT); end
                dma_n++; cpu_n = 0; issued = 1;
            end else if (vram_re && MA[15:12] == 4'hC) begin
                cpu_n++;
            end
            advance();
            if (sc) begin ca++; cpu_addr = ca; end
            if (sd) dma_req = 0;
            if (issued && dma_n == 1) begin dma_req = 1; dma_addr = 16'hD100; end
        end
        checks++; if (dma_n != 2) begin errors++; $display("FAIL starve_timeout: got %0d dma issues want 2", dma_n); end
        cpu_req = 0; dma_req = 0; char_cycle = 0;
        repeat (6) advance();
    endtask

    task automatic test_dma_disabled();
        for (int k = 0; k < 64; k++) begin
            drive_random(1);
            char_cycle = 3'($urandom);
            @(negedge clock);
            checks += 3;
            if (dma_ack !== 0) begin errors++; $display("FAIL nodma_ack: got %b want 0", dma_ack); end
            if (dma_rvalid !== 0 || dma_rdata !== 0) begin errors++; $display("FAIL nodma_rdata: got %b/%h want 0/0", dma_rvalid, dma_rdata); end
            if (MA === 16'hDDDD) begin errors++; $display("FAIL nodma_ma: got MA=%h want not dddd", MA); end
            advance();
        end
        dma_req = 0;
    endtask

    task automatic test_random();
        logic [15:0] ema, emd;
        logic        ere, ewe;
        for (int k = 0; k < 3000; k++) begin
            drive_random(0);
            if ((k / 64) % 2 == 1) begin
                bg_active = 1; char_cycle = (k % 2 == 1) ? 3'd0 : 3'd1;
            end else begin
                char_cycle = 3'($urandom);
            end
            if ($urandom_range(0, 299) == 0) begin reset_N = 0; model_reset(); end
            else reset_N = 1;
            @(negedge clock);
            m_outputs(ema, emd, ere, ewe);
            checks += 8;
            if (MA !== ema) begin errors++; $display("FAIL rnd_ma c%0d: got %h want %h", cyc, MA, ema); end
            if (MD_out !== emd) begin errors++; $display("FAIL rnd_md c%0d: got %h want %h", cyc, MD_out, emd); end
            if (vram_re !== ere || vram_we !== ewe) begin errors++; $display("FAIL rnd_strobe c%0d: got %b%b want %b%b", cyc, vram_re, vram_we, ere, ewe); end
            if (cpu_ack !== (cpu_req && !m_cpu_v)) begin errors++; $display("FAIL rnd_cpu_ack c%0d: got %b want %b", cyc, cpu_ack, cpu_req && !m_cpu_v); end
            if (dma_ack !== (DMA_EN && dma_req && !m_dma_v)) begin errors++; $display("FAIL rnd_dma_ack c%0d: got %b want %b", cyc, dma_ack, DMA_EN && dma_req && !m_dma_v); end
            if (cpu_rvalid !== m_cpu_rv || cpu_rdata !== m_cpu_rdata) begin
                errors++; $display("FAIL rnd_cpu_ret c%0d: got %b/%h want %b/%h", cyc, cpu_rvalid, cpu_rdata, m_cpu_rv, m_cpu_rdata);
            end
            if (dma_rvalid !== m_dma_rv) begin errors++; $display("FAIL rnd_dma_rv c%0d: got %b want %b", cyc, dma_rvalid, m_dma_rv); end
            if (dma_rdata !== m_dma_rdata) begin errors++; $display("FAIL rnd_dma_rd c%0d: got %h want %h", cyc, dma_rdata, m_dma_rdata); end
            advance();
        end
        reset_N = 1;
    endtask

    initial begin
        reset_N = 0; char_cycle = 0; bg_active = 0; bg_addr = 0; MD_in = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        model_reset();
        #1;
        test_reset();
        test_bg_slots();
        test_cpu_read();
        test_cpu_write();
        test_hold();
        test_reset_midflight();
`ifdef VDC_VRAM_DMA_EN
        test_starvation();
`else
        test_dma_disabled();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
